// File: rtl/score_tracker_if.sv
// Event/score bus between FlappyBlock game logic and the score tracker.
// The master side (game) drives events; the slave side (tracker) drives scores.
interface score_tracker_if;
  logic        start_btn;
  logic        pass_pulse;
  logic        collide;
  logic [13:0] number;
  logic [13:0] score;
  logic [13:0] high_score;
  logic [1:0]  state;
  logic        new_record;

  modport master (
    output start_btn, pass_pulse, collide,
    input  number, score, high_score, state, new_record
  );

  modport slave (
    input  start_btn, pass_pulse, collide,
    output number, score, high_score, state, new_record
  );
endinterface

// File: rtl/score_tracker.sv
// FlappyBlock score keeper: counts pipes passed, tracks the session high score
// and feeds the 2-digit display with a registered, blinking-in-OVER number.
module score_tracker #(
  parameter logic [13:0] MAX_SCORE    = 14'd99,
  parameter int unsigned BLINK_CYCLES = 32'd25_000_000
) (
  input logic            clk,
  input logic            rst_n,
  score_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t      state_r, state_n;
  logic        sync1_r, sync2_r, sync3_r, start_evt_r;
  logic [13:0] score_r, score_n;
  logic [13:0] high_r, high_n;
  logic [13:0] number_r, number_n;
  logic        rec_r, rec_n;
  logic [31:0] cnt_r, cnt_n;
  logic        phase_r, phase_n;
  logic [13:0] pass_sat_s;

  // Saturating pass count; feeds both the running score and the final-score record check.
  always_comb begin
    pass_sat_s = score_r;
    if (bus.pass_pulse) begin
      if (score_r >= MAX_SCORE) begin
        pass_sat_s = MAX_SCORE;
      end else begin
        pass_sat_s = score_r + 14'd1;
      end
    end else begin
      pass_sat_s = score_r;
    end
  end

  // Game FSM next-state, score/record bookkeeping and OVER blink timing.
  always_comb begin
    state_n = state_r;
    score_n = score_r;
    high_n  = high_r;
    rec_n   = rec_r;
    cnt_n   = cnt_r;
    phase_n = phase_r;
    case (state_r)
      ST_IDLE: begin
        if (start_evt_r) begin
          state_n = ST_PLAY;
          score_n = 14'd0;
          rec_n   = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PLAY: begin
        score_n = pass_sat_s;
        if (bus.collide) begin
          state_n = ST_OVER;
          cnt_n   = 32'd0;
          phase_n = 1'b0;
          // A pass in the collision cycle already counts toward the final score.
          if (pass_sat_s > high_r) begin
            high_n = pass_sat_s;
            rec_n  = 1'b1;
          end else begin
            high_n = high_r;
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_evt_r) begin
          state_n = ST_PLAY;
          score_n = 14'd0;
          rec_n   = 1'b0;
        end else if (cnt_r >= BLINK_CYCLES - 32'd1) begin
          cnt_n   = 32'd0;
          phase_n = ~phase_r;
        end else begin
          cnt_n   = cnt_r + 32'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Display source select; registered below so number lags its source by one cycle.
  always_comb begin
    number_n = 14'd0;
    case (state_r)
      ST_IDLE: number_n = high_r;
      ST_PLAY: number_n = score_r;
      ST_OVER: begin
        if (phase_r) begin
          number_n = high_r;
        end else begin
          number_n = score_r;
        end
      end
      default: number_n = 14'd0;
    endcase
  end

  // Start-button synchronizer, edge detect and all architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      sync3_r     <= 1'b0;
      start_evt_r <= 1'b0;
      state_r     <= ST_IDLE;
      score_r     <= 14'd0;
      high_r      <= 14'd0;
      rec_r       <= 1'b0;
      cnt_r       <= 32'd0;
      phase_r     <= 1'b0;
      number_r    <= 14'd0;
    end else begin
      sync1_r     <= bus.start_btn;
      sync2_r     <= sync1_r;
      sync3_r     <= sync2_r;
      start_evt_r <= sync2_r & ~sync3_r;
      state_r     <= state_n;
      score_r     <= score_n;
      high_r      <= high_n;
      rec_r       <= rec_n;
      cnt_r       <= cnt_n;
      phase_r     <= phase_n;
      number_r    <= number_n;
    end
  end

  assign bus.number     = number_r;
  assign bus.score      = score_r;
  assign bus.high_score = high_r;
  assign bus.state      = state_r;
  assign bus.new_record = rec_r;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: a driver steps a game-level reference
// model and queues expected outputs; a monitor compares after every clock edge.
module tb_score_tracker;

  localparam int BLINK = 4;
  localparam int MAXS  = 99;

  typedef struct {
    logic [13:0] number;
    logic [13:0] score;
    logic [13:0] high;
    logic [1:0]  state;
    logic        rec;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  score_tracker_if bus ();

  score_tracker #(
    .MAX_SCORE   (14'd99),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: game-level view (0 idle, 1 play, 2 over).
  int m_state = 0;
  int m_score = 0;
  int m_high  = 0;
  int m_rec   = 0;
  int m_age   = 0;   // edges spent in OVER since entry
  bit hist[5];       // start_btn as sampled on the last five edges, [0] newest

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_rec = 0; m_age = 0;
    for (int i = 0; i < 5; i++) hist[i] = 1'b0;
  endtask

  task automatic step(input bit btn, input bit p, input bit c);
    exp_t e;
    int   nxt_num;
    bit   evt;
    @(negedge clk);
    bus.start_btn  = btn;
    bus.pass_pulse = p;
    bus.collide    = c;
    if (m_state == 0)      nxt_num = m_high;
    else if (m_state == 1) nxt_num = m_score;
    else                   nxt_num = (((m_age / BLINK) % 2) == 1) ? m_high : m_score;
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn;
    // a press becomes a start event three samples after it was first seen
    evt = hist[3] && !hist[4];
    if (m_state == 1) begin
      if (p) m_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
      if (c) begin
        m_state = 2;
        m_age   = 0;
        if (m_score > m_high) begin
          m_high = m_score;
          m_rec  = 1;
        end
      end
    end else if (evt) begin
      m_state = 1;
      m_score = 0;
      m_rec   = 0;
    end else if (m_state == 2) begin
      m_age++;
    end
    e.number = 14'(nxt_num);
    e.score  = 14'(m_score);
    e.high   = 14'(m_high);
    e.state  = 2'(m_state);
    e.rec    = (m_rec != 0);
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start_btn = 1'b0; bus.pass_pulse = 1'b0; bus.collide = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.number !== 14'd0 || bus.score !== 14'd0 || bus.high_score !== 14'd0 ||
        bus.state !== 2'b00 || bus.new_record !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got number=%0d score=%0d high=%0d state=%0d rec=%0d, want all 0",
               bus.number, bus.score, bus.high_score, bus.state, bus.new_record);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press();
    repeat (10) step(1'b1, 1'b0, 1'b0);
    repeat (4)  step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every edge that has a queued expectation gets compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.number !== e.number || bus.score !== e.score || bus.high_score !== e.high ||
            bus.state !== e.state || bus.new_record !== e.rec) begin
          bad++;
          $display("FAIL scoreboard t=%0t: got num=%0d sc=%0d hi=%0d st=%0d rec=%0d, want num=%0d sc=%0d hi=%0d st=%0d rec=%0d",
                   $time, bus.number, bus.score, bus.high_score, bus.state, bus.new_record,
                   e.number, e.score, e.high, e.state, e.rec);
        end
      end
    end
  end

  initial begin
    bit lvl;
    bus.start_btn = 1'b0; bus.pass_pulse = 1'b0; bus.collide = 1'b0;
    model_reset();
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // game 1: seven passes, new record
    press();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // game 2: ties the high score, so no record; blink shows score/high
    press();
    repeat (7) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    // game 3: pass and collide together at score 4
    press();
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // game 4: saturation at 99
    press();
    repeat (120) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // game 5: reset mid-play at score 5
    press();
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // random play: slow button toggling, frequent passes, rare collisions
    lvl = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) lvl = ~lvl;
      step(lvl, ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
